// File: rtl/hht_pkg.sv
// Shared types and defaults for the HHT convolution engine: FSM state encoding,
// default parameter values and the result-width helper.
package hht_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_V,
      FILL,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam int DEF_N_TAPS = 9;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 32;

   // Wide enough that N_TAPS full-scale unsigned products can never overflow.
   function automatic int acc_width(input int data_w, input int n_taps);
      return 2 * data_w + $clog2(n_taps);
   endfunction

endpackage

// File: rtl/hht_mac_tree.sv
// Combinational N_TAPS-input unsigned multiply-add: sum of coef[k]*window[k],
// with every operand zero-extended to ACC_W before multiplying.
module hht_mac_tree
   import hht_pkg::*;
#(
   parameter int N_TAPS = DEF_N_TAPS,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = acc_width(DATA_W, N_TAPS)
) (
   input  logic [DATA_W-1:0] coef   [N_TAPS],
   input  logic [DATA_W-1:0] window [N_TAPS],
   output logic [ACC_W-1:0]  sum
);

   always_comb begin
      sum = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         sum = sum + ACC_W'(coef[k]) * ACC_W'(window[k]);
      end
   end

endmodule

// File: rtl/hht_conv_engine.sv
// HHT filter engine: loads an N_TAPS coefficient vector and a data column, then
// streams sliding-window dot products through a valid/ready output register.
module hht_conv_engine
   import hht_pkg::*;
#(
   parameter int N_TAPS = DEF_N_TAPS,
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int ACC_W  = acc_width(DATA_W, N_TAPS)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] v_base,
   input  logic [ADDR_W-1:0] col_base,
   input  logic [ADDR_W-1:0] col_size,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] addr2,
   input  logic [DATA_W-1:0] dataIn2,
   output logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] dataIn1,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic [ADDR_W-1:0] out_index
);

   localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] TAPS      = ADDR_W'(N_TAPS);
   localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(N_TAPS - 1);
   localparam logic [ADDR_W-1:0] LAST_FILL = ADDR_W'(N_TAPS - 2);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] v_base_q, col_base_q, col_size_q;
   logic [ADDR_W-1:0] cnt, res_idx;
   logic [DATA_W-1:0] coef   [N_TAPS];
   logic [DATA_W-1:0] hist   [N_TAPS-1];
   logic [DATA_W-1:0] window [N_TAPS];
   logic [ACC_W-1:0]  dot;
   logic              advance, shift;

   // The newest sample is used straight from the memory port, so only N_TAPS-1 are stored.
   always_comb begin
      for (int k = 0; k < N_TAPS - 1; k++) window[k] = hist[k];
      window[N_TAPS-1] = dataIn1;
   end

   hht_mac_tree #(
      .N_TAPS (N_TAPS),
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .coef   (coef),
      .window (window),
      .sum    (dot)
   );

   always_comb begin
      state_nx = state;
      addr1    = '0;
      addr2    = '0;
      advance  = 1'b0;
      case (state)
         IDLE:   if (start) state_nx = LOAD_V;
         LOAD_V: begin
            addr2 = v_base_q + cnt;
            if (cnt == LAST_TAP) state_nx = (col_size_q < TAPS) ? DONE : FILL;
         end
         FILL: begin
            addr1 = col_base_q + cnt;
            if (cnt == LAST_FILL) state_nx = RUN;
         end
         RUN: begin
            addr1   = col_base_q + cnt;
            advance = !out_valid || out_ready;
            if (advance && cnt == col_size_q - ONE) state_nx = DRAIN;
         end
         DRAIN:  if (!out_valid) state_nx = DONE;
         DONE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign shift = (state == FILL) || advance;
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state     <= IDLE;
         cnt       <= '0;
         res_idx   <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (start) begin
               cnt     <= '0;
               res_idx <= '0;
               err     <= 1'b0;
            end
            LOAD_V: begin
               cnt <= (cnt == LAST_TAP) ? '0 : cnt + ONE;
               if (state_nx == DONE) err <= 1'b1;
            end
            FILL: cnt <= cnt + ONE;
            RUN: if (advance) begin
               cnt       <= cnt + ONE;
               res_idx   <= res_idx + ONE;
               out_valid <= 1'b1;
               out_data  <= dot;
               out_index <= res_idx;
            end
            DRAIN: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   // Job parameters, coefficients and sample history carry no reset; they are
   // always written before they are consumed.
   always_ff @(posedge Clk) begin
      if (state == IDLE && start) begin
         v_base_q   <= v_base;
         col_base_q <= col_base;
         col_size_q <= col_size;
      end
      if (state == LOAD_V) begin
         for (int k = 0; k < N_TAPS; k++) begin
            if (cnt == ADDR_W'(k)) coef[k] <= dataIn2;
         end
      end
      if (shift) begin
         for (int k = 0; k < N_TAPS - 1; k++) hist[k] <= window[k+1];
      end
   end

endmodule

// File: tb/tb_hht_conv_engine.sv
// Bench for hht_conv_engine: a table of jobs against a 9-tap 32-bit instance plus
// reset and narrow-width (3-tap, 8-bit) sequences.
module tb_hht_conv_engine;

   localparam int NT = 9;
   localparam int VB = 2;
   localparam int CB = 340;
   localparam int CS_MAX = 102;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        start;
   logic [31:0] v_base_in, col_base_in, col_size_in;
   logic        busy, done, err;
   logic [31:0] addr2, dataIn2, addr1, dataIn1;
   logic        out_valid, out_ready;
   logic [67:0] out_data;
   logic [31:0] out_index;

   logic        start_s, ready_s;
   logic [15:0] v_base_s, col_base_s, col_size_s;
   logic        busy_s, done_s, err_s, out_valid_s;
   logic [15:0] addr2_s, addr1_s, out_index_s;
   logic [7:0]  dataIn2_s, dataIn1_s;
   logic [17:0] out_data_s;

   logic [31:0] vmem [NT];
   logic [31:0] xmem [CS_MAX];
   int          total = 0;
   int          bad = 0;
   logic [67:0] first_data_g;

   always #5 Clk = ~Clk;

   hht_conv_engine dut (
      .Clk(Clk), .Rst(Rst), .start(start), .v_base(v_base_in), .col_base(col_base_in),
      .col_size(col_size_in), .busy(busy), .done(done), .err(err), .addr2(addr2),
      .dataIn2(dataIn2), .addr1(addr1), .dataIn1(dataIn1), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_index(out_index)
   );

   hht_conv_engine #(.N_TAPS(3), .DATA_W(8), .ADDR_W(16)) dut_s (
      .Clk(Clk), .Rst(Rst), .start(start_s), .v_base(v_base_s), .col_base(col_base_s),
      .col_size(col_size_s), .busy(busy_s), .done(done_s), .err(err_s), .addr2(addr2_s),
      .dataIn2(dataIn2_s), .addr1(addr1_s), .dataIn1(dataIn1_s), .out_valid(out_valid_s),
      .out_ready(ready_s), .out_data(out_data_s), .out_index(out_index_s)
   );

   always_comb begin
      int a2, a1;
      a2 = int'(addr2) - VB;
      a1 = int'(addr1) - CB;
      dataIn2 = (a2 >= 0 && a2 < NT) ? vmem[a2] : 32'h0;
      dataIn1 = (a1 >= 0 && a1 < CS_MAX) ? xmem[a1] : 32'h0BAD_0BAD;
   end

   always_comb begin
      dataIn2_s = (addr2_s >= 16'h0010 && addr2_s < 16'h0013) ? 8'hFF : 8'h00;
      dataIn1_s = (addr1_s >= 16'h0100 && addr1_s < 16'h0104) ? 8'hFF : 8'h00;
   end

   function automatic logic [67:0] y_model(input int i);
      logic [67:0] s = '0;
      for (int k = 0; k < NT; k++) s += 68'(vmem[k]) * 68'(xmem[i+k]);
      return s;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_job(input string nm, input int cs, input int rdy, input bit poke,
                          input int exp_n, input bit exp_err);
      int          n_hs = 0;
      int          first_v = -1;
      int          done_e = -1;
      int          last_hs = -1;
      bit          fin = 1'b0;
      bit          prev_stall = 1'b0;
      bit          err_at_done = 1'b0;
      logic [67:0] prev_d = '0;
      logic [31:0] prev_i = '0;
      v_base_in = VB; col_base_in = CB; col_size_in = cs; start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      chk({nm, " start"}, {err, busy}, 2'b01);
      for (int e = 0; e < 1000 && !fin; e++) begin
         if (out_valid && first_v < 0) first_v = e;
         if (prev_stall)
            chk({nm, " hold"}, {out_valid, out_data, out_index}, {1'b1, prev_d, prev_i});
         if (done) begin
            fin = 1'b1; done_e = e; err_at_done = err;
         end else begin
            out_ready = ($urandom_range(99) < rdy);
            if (out_valid && out_ready) begin
               if (n_hs == 0) first_data_g = out_data;
               chk({nm, " y"}, {out_index, out_data}, {n_hs[31:0], y_model(n_hs)});
               n_hs++;
               last_hs = e + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_i = out_index;
            start = poke && (e == 2*NT + 10);
            if (start) begin
               v_base_in = 100; col_base_in = 0; col_size_in = 20;
            end
            @(posedge Clk); #1;
            start = 1'b0;
         end
      end
      if (!fin) begin
         total++; bad++;
         $display("FAIL %s timeout: done never seen, required within 1000 cycles", nm);
      end
      chk({nm, " count"}, n_hs, exp_n);
      chk({nm, " err"}, err_at_done, exp_err);
      if (exp_err) begin
         chk({nm, " err_cycle"}, done_e, NT);
         chk({nm, " no_valid"}, (first_v >= 0), 1'b0);
      end else begin
         chk({nm, " first_valid"}, first_v, 2*NT);
         chk({nm, " done_lat"}, done_e, last_hs + 1);
      end
      @(posedge Clk); #1;
      chk({nm, " after_done"}, {done, busy}, 2'b00);
   endtask

   typedef struct {
      int cs;
      int rdy;
      bit poke;
      int exp_n;
      bit exp_err;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [31:0] x0 [NT];
      int nd, ns;
      bit fin_s;
      x0 = '{30, 28, 8, 18, 2, 17, 31, 7, 28};
      vmem = '{7, 34, 50, 51, 95, 24, 49, 63, 34};
      for (int i = 0; i < CS_MAX; i++) xmem[i] = (i < NT) ? x0[i] : 32'((i*53 + 7) % 101);
      tbl[0] = '{102, 100, 1'b0, 94, 1'b0};
      tbl[1] = '{102,  50, 1'b0, 94, 1'b0};
      tbl[2] = '{  9, 100, 1'b0,  1, 1'b0};
      tbl[3] = '{  8, 100, 1'b0,  0, 1'b1};
      tbl[4] = '{102, 100, 1'b1, 94, 1'b0};
      tbl[5] = '{ 12,  30, 1'b0,  4, 1'b0};

      Rst = 1'b0; start = 1'b0; out_ready = 1'b0;
      v_base_in = '0; col_base_in = '0; col_size_in = '0;
      start_s = 1'b0; ready_s = 1'b0;
      v_base_s = '0; col_base_s = '0; col_size_s = '0;
      first_data_g = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset ctl", {busy, done, err, out_valid, busy_s, out_valid_s}, 6'b0);
      chk("reset data", out_data, 68'd0);
      chk("reset addr", {out_index, addr1, addr2}, 96'd0);
      Rst = 1'b1;
      @(posedge Clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_job($sformatf("job%0d", i), tbl[i].cs, tbl[i].rdy, tbl[i].poke,
                 tbl[i].exp_n, tbl[i].exp_err);
         if (tbl[i].exp_n > 0) chk($sformatf("job%0d y0", i), first_data_g, 68'd5990);
      end

      v_base_in = VB; col_base_in = CB; col_size_in = 102; out_ready = 1'b1; start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      repeat (25) @(posedge Clk);
      #1;
      chk("midrun state", {busy, out_valid}, 2'b11);
      Rst = 1'b0;
      @(posedge Clk); #1;
      Rst = 1'b1;
      chk("midrun rst ctl", {busy, done, err, out_valid}, 4'b0);
      chk("midrun rst data", out_data, 68'd0);
      chk("midrun rst addr", {out_index, addr1, addr2}, 96'd0);
      nd = 0;
      repeat (8) begin
         @(posedge Clk); #1;
         if (done || busy) nd++;
      end
      chk("midrun no_done", nd, 0);
      run_job("restart", 102, 100, 1'b0, 94, 1'b0);

      v_base_s = 16'h0010; col_base_s = 16'h0100; col_size_s = 16'd4;
      ready_s = 1'b1; start_s = 1'b1;
      @(posedge Clk); #1;
      start_s = 1'b0;
      chk("small busy", busy_s, 1'b1);
      ns = 0; fin_s = 1'b0;
      for (int e = 0; e < 100 && !fin_s; e++) begin
         if (done_s) begin
            fin_s = 1'b1;
            chk("small err", err_s, 1'b0);
         end else begin
            if (out_valid_s && ready_s) begin
               chk("small y", {out_index_s, out_data_s}, {16'(ns), 18'd195075});
               ns++;
            end
            @(posedge Clk); #1;
         end
      end
      if (!fin_s) begin
         total++; bad++;
         $display("FAIL small timeout: done never seen, required within 100 cycles");
      end
      chk("small count", ns, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
